// File: rtl/rfm_pkg.sv
// Shared types, sizes and helpers for the RFM bank tracker.
// RFM_CNT_SAT_EN: when defined, counters saturate at all-ones instead of wrapping.
package rfm_pkg;

  localparam int NUM_ENTRY      = 64;
  localparam int NUM_ENTRY_BITS = 6;
  localparam int RFM_TH         = 20;
  localparam int ADDR_SIZE      = 18;
  localparam int CNT_SIZE       = 32;

  localparam int QUAD_ENTRY = NUM_ENTRY / 4;
  localparam int QUAD_BITS  = NUM_ENTRY_BITS - 2;
  localparam int ASR_BITS   = $clog2(RFM_TH + 1);

  typedef logic [ADDR_SIZE-1:0]      addr_t;
  typedef logic [CNT_SIZE-1:0]       cnt_t;
  typedef logic [NUM_ENTRY_BITS-1:0] idx_t;

  function automatic idx_t pri_sel(input logic [NUM_ENTRY-1:0] vec);
    idx_t sel;
    sel = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (vec[i]) sel = idx_t'(i);
    end
    return sel;
  endfunction

  function automatic cnt_t cnt_inc(input cnt_t c);
`ifdef RFM_CNT_SAT_EN
    return (c == '1) ? c : c + cnt_t'(1);
`else
    return c + cnt_t'(1);
`endif
  endfunction

endpackage

// File: rtl/rfm_cam_quad.sv
// One quarter of the tracker table: address/count registers, match and eq-spill
// vectors, and the quarter's max count (lowest local index on ties).
module rfm_cam_quad
  import rfm_pkg::*;
#(
  parameter int QID = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDR_SIZE-1:0]      act_addr,
  input  logic [CNT_SIZE-1:0]       spill,
  input  logic                      wr_en,
  input  logic [NUM_ENTRY_BITS-1:0] wr_idx,
  input  logic [ADDR_SIZE-1:0]      wr_addr,
  input  logic [CNT_SIZE-1:0]       wr_cnt,
  output logic [QUAD_ENTRY-1:0]     match_vec,
  output logic [QUAD_ENTRY-1:0]     eq_vec,
  output logic [CNT_SIZE-1:0]       hit_cnt,
  output logic [CNT_SIZE-1:0]       max_cnt,
  output logic [ADDR_SIZE-1:0]      max_addr,
  output logic [NUM_ENTRY_BITS-1:0] max_idx
);

  localparam logic [1:0] QSEL = 2'(QID);

  addr_t addr_q [QUAD_ENTRY];
  addr_t addr_d [QUAD_ENTRY];
  cnt_t  cnt_q  [QUAD_ENTRY];
  cnt_t  cnt_d  [QUAD_ENTRY];

  logic                 wr_hit;
  logic [QUAD_BITS-1:0] wr_loc;
  logic [QUAD_BITS-1:0] max_loc;

  assign wr_hit  = wr_en && (wr_idx[NUM_ENTRY_BITS-1 -: 2] == QSEL);
  assign wr_loc  = wr_idx[QUAD_BITS-1:0];
  assign max_idx = {QSEL, max_loc};

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (wr_hit) begin
      addr_d[wr_loc] = wr_addr;
      cnt_d[wr_loc]  = wr_cnt;
    end
  end

  // Non-empty addresses are unique, so OR-ing matched counts yields the hit count.
  always_comb begin
    match_vec = '0;
    eq_vec    = '0;
    hit_cnt   = '0;
    max_cnt   = '0;
    max_addr  = '0;
    max_loc   = '0;
    for (int i = 0; i < QUAD_ENTRY; i++) begin
      match_vec[i] = (cnt_q[i] != '0) && (addr_q[i] == act_addr);
      eq_vec[i]    = (cnt_q[i] == spill);
      if (match_vec[i]) hit_cnt = hit_cnt | cnt_q[i];
      if (cnt_q[i] > max_cnt) begin
        max_cnt  = cnt_q[i];
        max_addr = addr_q[i];
        max_loc  = QUAD_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '{default: '0};
      cnt_q  <= '{default: '0};
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rfm_bank_tracker.sv
// Per-bank Misra-Gries RowHammer tracker issuing one NRR per RFM for the hottest row.
// RFM_CNT_SAT_EN: when defined, entry counts and spill saturate instead of wrapping.
module rfm_bank_tracker
  import rfm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 act_cmd,
  input  logic [ADDR_SIZE-1:0] act_addr,
  input  logic                 rfm_cmd,
  output logic                 nrr_cmd,
  output logic [ADDR_SIZE-1:0] nrr_addr
);

  logic                  act_q, rfm_q, pending_q, pending_d;
  addr_t                 act_addr_q;
  cnt_t                  spill_q, spill_d;
  logic [ASR_BITS-1:0]   asr_q, asr_d;
  logic                  nrr_cmd_q, nrr_cmd_d;
  addr_t                 nrr_addr_q, nrr_addr_d;

  logic [QUAD_ENTRY-1:0] q_match [4];
  logic [QUAD_ENTRY-1:0] q_eq    [4];
  cnt_t                  q_hit_cnt [4];
  cnt_t                  q_max_cnt [4];
  addr_t                 q_max_addr [4];
  idx_t                  q_max_idx  [4];

  logic [NUM_ENTRY-1:0]  match_all, eq_all;
  cnt_t                  hit_cnt, max_cnt;
  addr_t                 max_addr;
  idx_t                  max_idx;
  logic                  rfm_req;

  logic                  wr_en;
  idx_t                  wr_idx;
  addr_t                 wr_addr;
  cnt_t                  wr_cnt;

  for (genvar q = 0; q < 4; q++) begin : g_quad
    rfm_cam_quad #(.QID(q)) u_quad (
      .clk      (clk),
      .rstn     (rstn),
      .act_addr (act_addr_q),
      .spill    (spill_q),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_addr  (wr_addr),
      .wr_cnt   (wr_cnt),
      .match_vec(q_match[q]),
      .eq_vec   (q_eq[q]),
      .hit_cnt  (q_hit_cnt[q]),
      .max_cnt  (q_max_cnt[q]),
      .max_addr (q_max_addr[q]),
      .max_idx  (q_max_idx[q])
    );
  end

  always_comb begin
    match_all = '0;
    eq_all    = '0;
    hit_cnt   = '0;
    max_cnt   = '0;
    max_addr  = '0;
    max_idx   = '0;
    for (int q = 0; q < 4; q++) begin
      match_all[q*QUAD_ENTRY +: QUAD_ENTRY] = q_match[q];
      eq_all[q*QUAD_ENTRY +: QUAD_ENTRY]    = q_eq[q];
      hit_cnt = hit_cnt | q_hit_cnt[q];
      if (q_max_cnt[q] > max_cnt) begin
        max_cnt  = q_max_cnt[q];
        max_addr = q_max_addr[q];
        max_idx  = q_max_idx[q];
      end
    end
  end

  // An ACT always owns the single write port; any RFM waits in pending_rfm until a free cycle.
  always_comb begin
    spill_d    = spill_q;
    pending_d  = pending_q;
    nrr_cmd_d  = 1'b0;
    nrr_addr_d = nrr_addr_q;
    asr_d      = asr_q;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_addr    = '0;
    wr_cnt     = '0;
    rfm_req    = rfm_q | pending_q;

    if (act_q) begin
      pending_d = rfm_req;
      if (|match_all) begin
        wr_en   = 1'b1;
        wr_idx  = pri_sel(match_all);
        wr_addr = act_addr_q;
        wr_cnt  = cnt_inc(hit_cnt);
      end else if (|eq_all) begin
        wr_en   = 1'b1;
        wr_idx  = pri_sel(eq_all);
        wr_addr = act_addr_q;
        wr_cnt  = cnt_inc(spill_q);
      end else begin
        spill_d = cnt_inc(spill_q);
      end
    end else if (rfm_req) begin
      pending_d = 1'b0;
      if (max_cnt > spill_q) begin
        wr_en      = 1'b1;
        wr_idx     = max_idx;
        wr_addr    = max_addr;
        wr_cnt     = spill_q;
        nrr_cmd_d  = 1'b1;
        nrr_addr_d = max_addr;
      end
    end

    if (rfm_q) begin
      asr_d = '0;
    end else if (act_q && (asr_q != '1)) begin
      asr_d = asr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q      <= 1'b0;
      act_addr_q <= '0;
      rfm_q      <= 1'b0;
      pending_q  <= 1'b0;
      spill_q    <= '0;
      asr_q      <= '0;
      nrr_cmd_q  <= 1'b0;
      nrr_addr_q <= '0;
    end else begin
      act_q      <= act_cmd;
      act_addr_q <= act_addr;
      rfm_q      <= rfm_cmd;
      pending_q  <= pending_d;
      spill_q    <= spill_d;
      asr_q      <= asr_d;
      nrr_cmd_q  <= nrr_cmd_d;
      nrr_addr_q <= nrr_addr_d;
    end
  end

  assign nrr_cmd  = nrr_cmd_q;
  assign nrr_addr = nrr_addr_q;

endmodule

// File: tb/tb_rfm_bank_tracker.sv
// Directed bench for rfm_bank_tracker: per-cycle vector table plus hand-written corner sequences.
module tb_rfm_bank_tracker;

  logic        clk;
  logic        rstn;
  logic        act_cmd;
  logic [17:0] act_addr;
  logic        rfm_cmd;
  logic        nrr_cmd;
  logic [17:0] nrr_addr;

  int checks = 0;
  int errors = 0;
  logic [17:0] held_addr;

  typedef struct {
    string       name;
    logic        act;
    logic [17:0] addr;
    logic        rfm;
    logic        exp_nrr;
    logic [17:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  rfm_bank_tracker dut (
    .clk     (clk),
    .rstn    (rstn),
    .act_cmd (act_cmd),
    .act_addr(act_addr),
    .rfm_cmd (rfm_cmd),
    .nrr_cmd (nrr_cmd),
    .nrr_addr(nrr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic void add(input string nm, input logic a, input logic [17:0] ad,
                              input logic r, input logic en, input logic [17:0] ea);
    vec_t v;
    v.name = nm; v.act = a; v.addr = ad; v.rfm = r; v.exp_nrr = en; v.exp_addr = ea;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs, then check the outputs just after the sampling edge.
  task automatic cycle(input string nm, input logic a, input logic [17:0] ad,
                       input logic r, input logic en, input logic [17:0] ea);
    act_cmd  = a;
    act_addr = ad;
    rfm_cmd  = r;
    @(posedge clk);
    #1;
    act_cmd = 1'b0;
    rfm_cmd = 1'b0;
    if (en) held_addr = ea;
    chk({nm, ".nrr_cmd"}, 32'(nrr_cmd), 32'(en));
    chk({nm, ".nrr_addr"}, 32'(nrr_addr), 32'(held_addr));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    held_addr = '0;
    chk("reset.nrr_cmd", 32'(nrr_cmd), 0);
    chk("reset.nrr_addr", 32'(nrr_addr), 0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    act_cmd   = 1'b0;
    act_addr  = '0;
    rfm_cmd   = 1'b0;
    held_addr = '0;

    // Empty table: RFM yields nothing
    add("t1_rfm",   0, 0,  1, 0, 0);
    add("t1_w1",    0, 0,  0, 0, 0);
    add("t1_w2",    0, 0,  0, 0, 0);
    add("t1_w3",    0, 0,  0, 0, 0);
    // ACT 5,5,5,9 -> {5,3},{9,1}
    add("t2_a5a",   1, 5,  0, 0, 0);
    add("t2_a5b",   1, 5,  0, 0, 0);
    add("t2_a5c",   1, 5,  0, 0, 0);
    add("t2_a9",    1, 9,  0, 0, 0);
    add("t2_rfm1",  0, 0,  1, 0, 0);
    add("t2_nrr5",  0, 0,  0, 1, 5);
    add("t2_rfm2",  0, 0,  1, 0, 0);
    add("t2_nrr9",  0, 0,  0, 1, 9);
    add("t2_rfm3",  0, 0,  1, 0, 0);
    add("t2_none1", 0, 0,  0, 0, 0);
    add("t2_none2", 0, 0,  0, 0, 0);
    // Tie between 7 and 8 resolves to lowest index
    add("t4_a7",    1, 7,  0, 0, 0);
    add("t4_a8",    1, 8,  0, 0, 0);
    add("t4_rfm1",  0, 0,  1, 0, 0);
    add("t4_nrr7",  0, 0,  0, 1, 7);
    add("t4_rfm2",  0, 0,  1, 0, 0);
    add("t4_nrr8",  0, 0,  0, 1, 8);
    add("t4_rfm3",  0, 0,  1, 0, 0);
    add("t4_none1", 0, 0,  0, 0, 0);
    add("t4_none2", 0, 0,  0, 0, 0);
    // ACT and RFM together: NRR two cycles after the sampling edge
    add("t5_a3rfm", 1, 3,  1, 0, 0);
    add("t5_w1",    0, 0,  0, 0, 0);
    add("t5_nrr3",  0, 0,  0, 1, 3);
    add("t5_w2",    0, 0,  0, 0, 0);
    // Second RFM while pending is absorbed
    add("ab_a4rfm", 1, 4,  1, 0, 0);
    add("ab_rfm",   0, 0,  1, 0, 0);
    add("ab_nrr4",  0, 0,  0, 1, 4);
    add("ab_none1", 0, 0,  0, 0, 0);
    add("ab_none2", 0, 0,  0, 0, 0);
    // Back-to-back ACT keeps the RFM deferred
    add("cl_a10rfm",1, 10, 1, 0, 0);
    add("cl_a11",   1, 11, 0, 0, 0);
    add("cl_w1",    0, 0,  0, 0, 0);
    add("cl_nrr10", 0, 0,  0, 1, 10);
    add("cl_rfm",   0, 0,  1, 0, 0);
    add("cl_nrr11", 0, 0,  0, 1, 11);
    add("cl_none",  0, 0,  0, 0, 0);

    #2;
    chk("init.nrr_cmd", 32'(nrr_cmd), 0);
    chk("init.nrr_addr", 32'(nrr_addr), 0);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].name, tbl[i].act, tbl[i].addr, tbl[i].rfm, tbl[i].exp_nrr, tbl[i].exp_addr);
    end

    // Full table, spill, and replacement of entries whose count equals spill
    do_reset();
    for (int i = 1; i <= 64; i++) cycle("t3_fill", 1, 18'(i), 0, 0, 0);
    cycle("t3_a100",   1, 100, 0, 0, 0);
    cycle("t3_a101",   1, 101, 0, 0, 0);
    cycle("t3_a64",    1, 64,  0, 0, 0);
    cycle("t3_rfm1",   0, 0,   1, 0, 0);
    cycle("t3_nrr101", 0, 0,   0, 1, 101);
    cycle("t3_rfm2",   0, 0,   1, 0, 0);
    cycle("t3_nrr64",  0, 0,   0, 1, 64);
    cycle("t3_rfm3",   0, 0,   1, 0, 0);
    cycle("t3_none",   0, 0,   0, 0, 0);
    cycle("t3_a100b",  1, 100, 0, 0, 0);
    cycle("t3_rfm4",   0, 0,   1, 0, 0);
    cycle("t3_nrr100", 0, 0,   0, 1, 100);

    // Reset while an NRR is pending
    cycle("t6_a5rfm", 1, 5, 1, 0, 100);
    rstn = 1'b0;
    #1;
    chk("t6_async.nrr_addr", 32'(nrr_addr), 0);
    @(posedge clk);
    #1;
    held_addr = '0;
    chk("t6_rst.nrr_cmd", 32'(nrr_cmd), 0);
    chk("t6_rst.nrr_addr", 32'(nrr_addr), 0);
    rstn = 1'b1;
    cycle("t6_w1",   0, 0, 0, 0, 0);
    cycle("t6_w2",   0, 0, 0, 0, 0);
    cycle("t6_rfm",  0, 0, 1, 0, 0);
    cycle("t6_none1",0, 0, 0, 0, 0);
    cycle("t6_none2",0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
